uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmit path: accepts an 8-bit byte on a send pulse and builds the frame start(0), data[7:0] LSB-first, optional parity, stop(1).
- Serializes the frame onto a single tx line at CLKS_PER_BIT clocks per bit.
- Sits opposite the Rx SIPO/deframe path. Frame bit order matches the Rx 11-bit layout: [0] start, [8:1] data, [9] parity, [10] stop.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535; bit counter width is $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- send  input  1  request to transmit data_in; sampled every cycle
- data_in  input  8  byte to transmit; sampled only in the accept cycle
- parity_type  input  2  00 none, 01 odd, 10 even, 11 none; sampled only in the accept cycle
- tx  output  1  serial line, idle high
- busy  output  1  high while a frame is in flight
- done_flag  output  1  one-cycle pulse when the last stop bit completes
- frame_out  output  11  latched frame, layout [10] stop, [9] parity, [8:1] data, [0] start; bit 9 = 1 when parity is none

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, tx=1, busy=0, done_flag=0, frame_out=11'h7FF, baud and bit counters=0. Reset mid-frame aborts the frame immediately; tx returns high on the next cycle.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. PARITY is skipped when parity_type is none at accept.
- Accept: in IDLE with send=1, the block latches data_in and parity_type and computes the parity bit. Even parity = ^data_in; odd parity = ~^data_in. Next cycle: state=START, tx=0, busy=1.
- send while busy is ignored and has no side effects. send is level-sampled: if held high, a new frame is accepted as soon as the block returns to IDLE.
- Each bit holds tx stable for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and advances the bit on terminal count.
- DATA: 8 bits, data[0] first; a 3-bit index counts 0..7.
- Frame length: 11*CLKS_PER_BIT cycles with parity, 10*CLKS_PER_BIT without (per stop bit count below).
- Last STOP cycle end: the next cycle has state=IDLE, busy=0, done_flag=1 for exactly one cycle, tx=1.
- Back-to-back: send=1 in the done_flag cycle is accepted, so the next start bit begins one cycle later. Minimum inter-frame idle is 1 cycle.
- frame_out updates at accept and holds until the next accept or reset.
- Changes on data_in or parity_type during a frame do not affect the frame in flight.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2*CLKS_PER_BIT cycles (two stop bits); frame is one bit longer; done_flag fires after the second stop bit.
- Undefined: one stop bit. Port list is identical in both builds.

Test Plan:
- CLKS_PER_BIT=4, reset, then send=1 for 1 cycle with data_in=8'hA5, parity_type=10 (even):
  - tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,0,1.
  - frame_out=11'b10_1010_0101_0.
  - busy high for 44 cycles, then done_flag pulses once.
- data_in=8'h00, parity_type=01 (odd): parity bit=1. parity_type=00: 10-bit frame with no parity slot, done_flag after 40 cycles.
- send re-asserted with 8'hFF mid-frame: ignored; tx output matches the first byte exactly and frame_out is unchanged.
- send held high continuously with 8'h3C: consecutive frames separated by exactly 1 idle-high cycle; done_flag pulses once per frame.
- rst=1 during DATA bit 3: next cycle tx=1, busy=0, done_flag=0. A new send after reset produces a clean full frame.
- UART_TX_TWO_STOP_EN defined, 8'h81 with even parity: tx high for 8 cycles at the end, done_flag at cycle 48 after accept.

Source files
------------

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// UART transmit framer/serializer. A byte accepted on `send` (while idle) is
// framed as start(0), data[7:0] LSB-first, optional parity, stop(1) and
// shifted out on `tx`, each bit held for CLKS_PER_BIT clocks.
//
// Optional build macro:
//   UART_TX_TWO_STOP_EN  - when defined, the frame carries two stop bits and
//                          done_flag fires after the second one. Port list is
//                          identical in both builds.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (2..65535)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   send         transmit request, level-sampled every cycle
//   data_in      byte to send, sampled only in the accept cycle
//   parity_type  00/11 none, 01 odd, 10 even; sampled only in accept cycle
//   tx           serial line, idle high
//   busy         high while a frame is in flight
//   done_flag    one-cycle pulse after the last stop bit completes
//   frame_out    latched frame {stop, parity, data[7:0], start}; the parity
//                slot reads 1 when parity is disabled
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [7:0]  data_in,
  input  logic [1:0]  parity_type,
  output logic        tx,
  output logic        busy,
  output logic        done_flag,
  output logic [10:0] frame_out
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned STOP_BITS = 2;
`else
  localparam int unsigned STOP_BITS = 1;
`endif
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             stop_idx_q, stop_idx_d;

  logic [7:0]       data_q;
  logic             par_bit_q;
  logic             par_en_q;

  logic             accept_c;
  logic             baud_end_c;
  logic             par_en_c;
  logic             par_bit_c;

  logic             tx_d;
  logic             busy_d;
  logic             done_d;

  // Accept decision and parity computed from the live inputs.
  assign accept_c   = (state_q == S_IDLE) && send;
  assign baud_end_c = (baud_q == BAUD_LAST);
  assign par_en_c   = (parity_type == 2'b01) || (parity_type == 2'b10);
  // Even parity makes the total ones count even; odd is its complement.
  assign par_bit_c  = parity_type[1] ? (^data_in) : (~^data_in);

  // State and counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;

    if (state_q != S_IDLE) begin
      baud_d = baud_end_c ? '0 : (baud_q + CNT_W'(1));
    end

    case (state_q)
      S_IDLE: begin
        baud_d     = '0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        if (send) begin
          state_d = S_START;
        end
      end

      S_START: begin
        bit_idx_d = '0;
        if (baud_end_c) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_end_c) begin
          if (bit_idx_q == 3'd7) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        stop_idx_d = 1'b0;
        if (baud_end_c) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (baud_end_c) begin
          if (stop_idx_q == STOP_LAST) begin
            state_d = S_IDLE;
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_idx_d];
      S_PARITY: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx        <= 1'b1;
      busy      <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      tx        <= tx_d;
      busy      <= busy_d;
      done_flag <= done_d;
    end
  end

  // Frame payload latched at accept; held through the frame and afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      frame_out <= 11'h7FF;
    end else if (accept_c) begin
      data_q    <= data_in;
      par_bit_q <= par_bit_c;
      par_en_q  <= par_en_c;
      frame_out <= {1'b1, (par_en_c ? par_bit_c : 1'b1), data_in, 1'b0};
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Self-checking bench for uart_tx_frame at CLKS_PER_BIT=4. A waveform-level
// reference model expands each accepted byte into its expected tx sequence
// and is compared against the DUT every cycle; a vector table and a few
// directed sequences cover frame contents, lengths and corner cases.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int unsigned CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
  localparam int unsigned STOP_BITS = 2;
`else
  localparam int unsigned STOP_BITS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [7:0]  data_in;
  logic [1:0]  parity_type;
  logic        tx;
  logic        busy;
  logic        done_flag;
  logic [10:0] frame_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  uart_tx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .send        (send),
    .data_in     (data_in),
    .parity_type (parity_type),
    .tx          (tx),
    .busy        (busy),
    .done_flag   (done_flag),
    .frame_out   (frame_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // q holds the remaining expected tx values, one entry per clock cycle.
  bit          q[$];
  bit          exp_done  = 1'b0;
  logic [10:0] exp_frame = 11'h7FF;

  task automatic model_accept(input logic [7:0] d, input logic [1:0] pt);
    int  ones;
    bit  pen;
    bit  pbit;
    bit  bits[$];
    ones = $countones(d);
    pen  = (pt == 2'b01) || (pt == 2'b10);
    pbit = (pt == 2'b10) ? bit'(ones % 2) : bit'((ones % 2) == 0);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    for (int i = 0; i < int'(STOP_BITS); i++) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < int'(CPB); k++) q.push_back(bits[i]);
    exp_frame = {1'b1, (pen ? pbit : 1'b1), d, 1'b0};
  endtask

  initial forever begin
    @(posedge clk);
    if (rst === 1'b1) begin
      q.delete();
      exp_done  = 1'b0;
      exp_frame = 11'h7FF;
    end else if (q.size() == 0) begin
      exp_done = 1'b0;
      if (send === 1'b1) model_accept(data_in, parity_type);
    end else begin
      void'(q.pop_front());
      exp_done = (q.size() == 0);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_tx",    32'(tx),        32'((q.size() > 0) ? q[0] : 1'b1));
      check("cyc_busy",  32'(busy),      32'(q.size() > 0));
      check("cyc_done",  32'(done_flag), 32'(exp_done));
      check("cyc_frame", 32'(frame_out), 32'(exp_frame));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input bit keep_send, input int max_cyc,
                           output int busy_cnt, output bit ok);
    busy_cnt = 0;
    ok       = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!keep_send) send = 1'b0;
      data_in     = 8'($urandom);
      parity_type = 2'($urandom);
      if (busy) busy_cnt++;
      if (done_flag) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  ptype;
    logic [10:0] frame;
    int          bits;   // frame bits with a single stop bit
  } vec_t;

  vec_t vecs[7];
  int   bcnt;
  bit   ok;

  initial begin
    vecs[0] = '{8'hA5, 2'b10, 11'h54A, 11};
    vecs[1] = '{8'h00, 2'b01, 11'h600, 11};
    vecs[2] = '{8'h00, 2'b00, 11'h600, 10};
    vecs[3] = '{8'hFF, 2'b10, 11'h5FE, 11};
    vecs[4] = '{8'h81, 2'b01, 11'h702, 11};
    vecs[5] = '{8'h3C, 2'b11, 11'h678, 10};
    vecs[6] = '{8'h81, 2'b10, 11'h502, 11};

    rst = 1'b1; send = 1'b0; data_in = 8'h00; parity_type = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx",    32'(tx),        32'd1);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done_flag), 32'd0);
    check("rst_frame", 32'(frame_out), 32'h7FF);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table: frame contents and busy length per vector.
    foreach (vecs[i]) begin
      send = 1'b1; data_in = vecs[i].data; parity_type = vecs[i].ptype;
      wait_done(1'b0, 200, bcnt, ok);
      check("vec_done_seen", 32'(ok), 32'd1);
      check("vec_busy_len", 32'(bcnt), 32'((vecs[i].bits + int'(STOP_BITS) - 1) * int'(CPB)));
      check("vec_frame", 32'(frame_out), 32'(vecs[i].frame));
      @(negedge clk);
      check("vec_done_once", 32'(done_flag), 32'd0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // send with 8'hFF while busy is ignored.
    send = 1'b1; data_in = 8'hA5; parity_type = 2'b10;
    @(negedge clk);
    send = 1'b0;
    repeat (9) @(negedge clk);
    send = 1'b1; data_in = 8'hFF; parity_type = 2'b01;
    @(negedge clk);
    send = 1'b0;
    repeat (15) @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    check("ign_frame_mid", 32'(frame_out), 32'h54A);
    wait_done(1'b0, 200, bcnt, ok);
    check("ign_done_seen", 32'(ok), 32'd1);
    check("ign_frame_end", 32'(frame_out), 32'h54A);
    repeat (3) @(negedge clk);

    // send held high: one idle cycle (the done cycle) between frames.
    send = 1'b1; data_in = 8'h3C; parity_type = 2'b10;
    for (int f = 0; f < 3; f++) begin
      wait_done(1'b1, 200, bcnt, ok);
      check("b2b_done_seen", 32'(ok), 32'd1);
      check("b2b_idle_busy", 32'(busy), 32'd0);
      check("b2b_idle_tx",   32'(tx),   32'd1);
      @(negedge clk);
      check("b2b_restart_busy", 32'(busy), 32'd1);
      check("b2b_restart_tx",   32'(tx),   32'd0);
    end
    send = 1'b0;
    wait_done(1'b0, 200, bcnt, ok);
    check("b2b_last_done", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);

    // Reset during data bit 3, then a clean frame.
    send = 1'b1; data_in = 8'h96; parity_type = 2'b01;
    @(negedge clk);
    send = 1'b0;
    repeat (17) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tx",    32'(tx),        32'd1);
    check("mid_rst_busy",  32'(busy),      32'd0);
    check("mid_rst_done",  32'(done_flag), 32'd0);
    check("mid_rst_frame", 32'(frame_out), 32'h7FF);
    @(negedge clk);
    send = 1'b1; data_in = 8'hA5; parity_type = 2'b10;
    wait_done(1'b0, 200, bcnt, ok);
    check("post_rst_done", 32'(ok), 32'd1);
    check("post_rst_len",  32'(bcnt), 32'((10 + int'(STOP_BITS)) * int'(CPB)));
    check("post_rst_frame", 32'(frame_out), 32'h54A);

    // Random traffic against the model, with rare resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      send        = ($urandom_range(0, 5) == 0);
      data_in     = 8'($urandom);
      parity_type = 2'($urandom);
      rst         = ($urandom_range(0, 249) == 0);
    end
    @(negedge clk);
    rst = 1'b0; send = 1'b0;
    repeat (60) @(negedge clk);
    check("end_idle_busy", 32'(busy), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
